monopix_hit_decoder: RTL and testbench

- Receives 27-bit MONOPIX hit words from the serial readout controller after they have crossed into the clk_bx domain.
- Converts the gray-coded leading-edge (LE) and trailing-edge (TE) timestamps to binary and computes time-over-threshold (ToT).
- Extends LE to a full 16-bit bunch-crossing timestamp using a local BX counter, drops out-of-range rows, and buffers results in a first-word-fall-through (FWFT) FIFO for the DAQ sink.

---
 rtl/monopix_pkg.sv | 36 +++
 rtl/monopix_hit_decoder_if.sv | 20 ++
 rtl/hit_fifo.sv | 61 ++++++
 rtl/monopix_hit_decoder.sv | 109 ++++++++++
 tb/tb_monopix_hit_decoder.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/monopix_pkg.sv
// Shared types, field widths and the gray decoder for the MONOPIX hit decoder.
package monopix_pkg;

  localparam int LE_W   = 6;
  localparam int TS_W   = 16;
  localparam int ROW_W  = 9;
  localparam int COL_W  = 6;
  localparam int BXHI_W = TS_W - LE_W;

  // Raw word from the readout controller; LE and TE are gray-coded.
  typedef struct packed {
    logic [COL_W-1:0] col;
    logic [LE_W-1:0]  te;
    logic [LE_W-1:0]  le;
    logic [ROW_W-1:0] row;
  } t_data;

  typedef struct packed {
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic [TS_W-1:0]  ts;
    logic [LE_W-1:0]  tot;
  } t_hit;

  localparam int HIT_W = $bits(t_hit);

  function automatic logic [5:0] gray2bin6(input logic [5:0] g);
    logic [5:0] b;
    b[5] = g[5];
    for (int i = 4; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/monopix_hit_decoder_if.sv
// Hit input strobe and the FWFT output handshake towards the DAQ sink.
interface monopix_hit_decoder_if;

  logic                in_valid;
  monopix_pkg::t_data  in_data;
  logic                out_valid;
  logic                out_ready;
  monopix_pkg::t_hit   out_hit;

  modport master (
    output in_valid, in_data, out_ready,
    input  out_valid, out_hit
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output out_valid, out_hit
  );

endinterface

// File: rtl/hit_fifo.sv
// Synchronous first-word-fall-through FIFO with registered full/empty flags.
module hit_fifo #(
  parameter int WIDTH = 37,
  parameter int DEPTH = 16
) (
  input  logic             clk_bx,
  input  logic             reset,
  input  logic             i_wr_en,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_rd_en,
  output logic [WIDTH-1:0] o_rd_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             r_full;
  logic             r_empty;
  logic             w_wr;
  logic             w_rd;
  logic [AW:0]      w_wr_ptr_nxt;
  logic [AW:0]      w_rd_ptr_nxt;

  // Flags are the registered state, so a same-cycle pop never frees room for a push.
  assign w_wr         = i_wr_en && !r_full;
  assign w_rd         = i_rd_en && !r_empty;
  assign w_wr_ptr_nxt = r_wr_ptr + (AW+1)'(w_wr);
  assign w_rd_ptr_nxt = r_rd_ptr + (AW+1)'(w_rd);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_bx) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      r_wr_ptr <= w_wr_ptr_nxt;
      r_rd_ptr <= w_rd_ptr_nxt;
      r_empty  <= (w_wr_ptr_nxt == w_rd_ptr_nxt);
      r_full   <= (w_wr_ptr_nxt[AW] != w_rd_ptr_nxt[AW]) &&
                  (w_wr_ptr_nxt[AW-1:0] == w_rd_ptr_nxt[AW-1:0]);
    end
  end

  // NOTE: storage is deliberately not reset; the empty flag masks stale entries.
  always_ff @(posedge clk_bx) begin
    if (w_wr) begin
      r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
    end
  end

  assign o_rd_data = r_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];
  assign o_full    = r_full;
  assign o_empty   = r_empty;

endmodule

// File: rtl/monopix_hit_decoder.sv
// Decodes MONOPIX hit words: gray LE/TE to binary, ToT, BX timestamp extension,
// row filtering, and buffering into an FWFT FIFO with overflow/invalid counters.
module monopix_hit_decoder
  import monopix_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int NROWS      = 224
) (
  input  logic                 clk_bx,
  input  logic                 reset,
  monopix_hit_decoder_if.slave bus,
  output logic [TS_W-1:0]      bx_cnt,
  output logic [TS_W-1:0]      ovf_cnt,
  output logic [TS_W-1:0]      inv_cnt
);

  localparam logic [ROW_W:0] ROW_LIMIT = (ROW_W+1)'(NROWS);

  logic [TS_W-1:0]   r_bx_cnt;
  logic [TS_W-1:0]   r_ovf_cnt;
  logic [TS_W-1:0]   r_inv_cnt;
  logic              r_s1_valid;
  logic              r_s1_row_ok;
  t_hit              r_s1_hit;

  logic [LE_W-1:0]   w_le_bin;
  logic [LE_W-1:0]   w_te_bin;
  logic [LE_W-1:0]   w_tot;
  logic [BXHI_W-1:0] w_bx_hi;
  logic [TS_W-1:0]   w_ts;
  logic              w_row_ok;
  logic              w_fifo_full;
  logic              w_fifo_empty;
  logic              w_wr_en;
  logic              w_drop_ovf;
  logic              w_drop_inv;

  always_ff @(posedge clk_bx) begin
    if (reset) begin
      r_bx_cnt <= '0;
    end else begin
      r_bx_cnt <= r_bx_cnt + 16'd1;
    end
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_le_bin = gray2bin6(bus.in_data.le);
    w_te_bin = gray2bin6(bus.in_data.te);
    w_tot    = w_te_bin - w_le_bin;
    w_bx_hi  = r_bx_cnt[TS_W-1:LE_W];
    // An LE ahead of the current BX low bits was latched in the previous 64-BX window.
    if (w_le_bin > r_bx_cnt[LE_W-1:0]) begin
      w_bx_hi = w_bx_hi - 10'd1;
    end
    w_ts     = {w_bx_hi, w_le_bin};
    w_row_ok = {1'b0, bus.in_data.row} < ROW_LIMIT;
  end

  always_ff @(posedge clk_bx) begin
    if (reset) begin
      r_s1_valid  <= 1'b0;
      r_s1_row_ok <= 1'b0;
      r_s1_hit    <= '0;
    end else begin
      r_s1_valid  <= bus.in_valid;
      r_s1_row_ok <= w_row_ok;
      r_s1_hit    <= '{col: bus.in_data.col, row: bus.in_data.row, ts: w_ts, tot: w_tot};
    end
  end

  assign w_wr_en    = r_s1_valid && r_s1_row_ok && !w_fifo_full;
  assign w_drop_ovf = r_s1_valid && r_s1_row_ok && w_fifo_full;
  assign w_drop_inv = r_s1_valid && !r_s1_row_ok;

  always_ff @(posedge clk_bx) begin
    if (reset) begin
      r_ovf_cnt <= '0;
      r_inv_cnt <= '0;
    end else begin
      if (w_drop_ovf && (r_ovf_cnt != '1)) begin
        r_ovf_cnt <= r_ovf_cnt + 16'd1;
      end
      if (w_drop_inv && (r_inv_cnt != '1)) begin
        r_inv_cnt <= r_inv_cnt + 16'd1;
      end
    end
  end

  hit_fifo #(
    .WIDTH (HIT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_hit_fifo (
    .clk_bx    (clk_bx),
    .reset     (reset),
    .i_wr_en   (w_wr_en),
    .i_wr_data (r_s1_hit),
    .i_rd_en   (bus.out_ready),
    .o_rd_data (bus.out_hit),
    .o_full    (w_fifo_full),
    .o_empty   (w_fifo_empty)
  );

  assign bus.out_valid = !w_fifo_empty;
  assign bx_cnt        = r_bx_cnt;
  assign ovf_cnt       = r_ovf_cnt;
  assign inv_cnt       = r_inv_cnt;

endmodule

// File: tb/tb_monopix_hit_decoder.sv
// Directed bench for monopix_hit_decoder: vector table plus overflow/drain/reset sequences.
module tb_monopix_hit_decoder;
  import monopix_pkg::*;

  logic        clk_bx = 1'b0;
  logic        reset;
  logic [15:0] bx_cnt;
  logic [15:0] ovf_cnt;
  logic [15:0] inv_cnt;
  int          total = 0;
  int          bad   = 0;

  typedef struct {
    logic [15:0] bx_at;
    t_data       din;
    logic        exp_valid;
    t_hit        exp_hit;
    logic [15:0] exp_inv;
  } vec_t;

  vec_t vecs [8];
  t_hit exp_q [20];

  monopix_hit_decoder_if bus ();

  monopix_hit_decoder #(
    .FIFO_DEPTH (16),
    .NROWS      (224)
  ) dut (
    .clk_bx  (clk_bx),
    .reset   (reset),
    .bus     (bus.slave),
    .bx_cnt  (bx_cnt),
    .ovf_cnt (ovf_cnt),
    .inv_cnt (inv_cnt)
  );

  always #5 clk_bx = ~clk_bx;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_bx(input logic [15:0] target);
    int n = 0;
    while (bx_cnt !== target && n < 400) begin
      @(negedge clk_bx);
      n++;
    end
    check("bx_wait", 64'(bx_cnt), 64'(target));
  endtask

  function automatic vec_t mk(input logic [15:0] bx, input logic [5:0] col, input logic [8:0] row,
                              input logic [5:0] le_g, input logic [5:0] te_g, input logic ev,
                              input logic [15:0] ts, input logic [5:0] tot, input logic [15:0] inv);
    vec_t v;
    v.bx_at       = bx;
    v.din.col     = col;
    v.din.te      = te_g;
    v.din.le      = le_g;
    v.din.row     = row;
    v.exp_valid   = ev;
    v.exp_hit.col = col;
    v.exp_hit.row = row;
    v.exp_hit.ts  = ts;
    v.exp_hit.tot = tot;
    v.exp_inv     = inv;
    return v;
  endfunction

  initial begin
    //            bx        col    row     le gray     te gray     vld   ts         tot   inv
    vecs[0] = mk(16'h0002, 6'd1,  9'd0,   6'b000111, 6'b000100, 1'b1, 16'hFFC5, 6'd2, 16'd0);
    vecs[1] = mk(16'h0105, 6'd3,  9'd10,  6'b000010, 6'b000111, 1'b1, 16'h0103, 6'd2, 16'd0);
    vecs[2] = mk(16'h0109, 6'd5,  9'd100, 6'b001111, 6'b001010, 1'b1, 16'h00CA, 6'd2, 16'd0);
    vecs[3] = mk(16'h0110, 6'd63, 9'd223, 6'b100010, 6'b000011, 1'b1, 16'h00FC, 6'd6, 16'd0);
    vecs[4] = mk(16'h0114, 6'd7,  9'd224, 6'b000000, 6'b000000, 1'b0, 16'h0000, 6'd0, 16'd1);
    vecs[5] = mk(16'h0118, 6'd8,  9'd511, 6'b000000, 6'b000000, 1'b0, 16'h0000, 6'd0, 16'd2);
    vecs[6] = mk(16'h011C, 6'd0,  9'd0,   6'b010010, 6'b010010, 1'b1, 16'h011C, 6'd0, 16'd2);
    vecs[7] = mk(16'h013F, 6'd2,  9'd1,   6'b100000, 6'b000000, 1'b1, 16'h013F, 6'd1, 16'd2);

    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    reset         = 1'b1;
    repeat (3) @(negedge clk_bx);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out_hit",   64'(bus.out_hit),   64'd0);
    check("rst_bx_cnt",    64'(bx_cnt),        64'd0);

    reset = 1'b0;
    repeat (100) @(negedge clk_bx);
    check("idle_bx_cnt",    64'(bx_cnt),        64'd100);
    check("idle_out_valid", 64'(bus.out_valid), 64'd0);
    check("idle_ovf_cnt",   64'(ovf_cnt),       64'd0);
    check("idle_inv_cnt",   64'(inv_cnt),       64'd0);

    // Restart the BX counter so the table timestamps are reachable quickly.
    reset = 1'b1;
    @(negedge clk_bx);
    reset         = 1'b0;
    bus.out_ready = 1'b1;

    for (int i = 0; i < 8; i++) begin
      wait_bx(vecs[i].bx_at);
      bus.in_data  = vecs[i].din;
      bus.in_valid = 1'b1;
      @(negedge clk_bx);
      bus.in_valid = 1'b0;
      @(negedge clk_bx);
      check($sformatf("v%0d_valid", i), 64'(bus.out_valid), 64'(vecs[i].exp_valid));
      if (vecs[i].exp_valid) begin
        check($sformatf("v%0d_hit", i), 64'(bus.out_hit), 64'(vecs[i].exp_hit));
      end
      check($sformatf("v%0d_inv", i), 64'(inv_cnt), 64'(vecs[i].exp_inv));
    end
    @(negedge clk_bx);
    check("table_drained", 64'(bus.out_valid), 64'd0);

    // Overflow: 20 back-to-back words into a 16-deep FIFO with the sink stalled.
    bus.out_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      bus.in_data = '{col: 6'(i), te: 6'd0, le: 6'd0, row: 9'(i)};
      exp_q[i]    = '{col: 6'(i), row: 9'(i), ts: bx_cnt & 16'hFFC0, tot: 6'd0};
      bus.in_valid = 1'b1;
      @(negedge clk_bx);
    end
    bus.in_valid = 1'b0;
    repeat (2) @(negedge clk_bx);
    check("ovf_cnt",       64'(ovf_cnt),       64'd4);
    check("ovf_inv_cnt",   64'(inv_cnt),       64'd2);
    check("ovf_out_valid", 64'(bus.out_valid), 64'd1);
    check("ovf_head_held", 64'(bus.out_hit),   64'(exp_q[0]));

    bus.out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check($sformatf("drain%0d_valid", i), 64'(bus.out_valid), 64'd1);
      check($sformatf("drain%0d_hit", i),   64'(bus.out_hit),   64'(exp_q[i]));
      @(negedge clk_bx);
    end
    check("drain_empty", 64'(bus.out_valid), 64'd0);

    // Reset in the middle of a drain, with a strobe in the reset cycle.
    bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.in_data = '{col: 6'(10 + i), te: 6'd0, le: 6'd0, row: 9'(50 + i)};
      exp_q[i]    = '{col: 6'(10 + i), row: 9'(50 + i), ts: bx_cnt & 16'hFFC0, tot: 6'd0};
      bus.in_valid = 1'b1;
      @(negedge clk_bx);
    end
    bus.in_valid = 1'b0;
    repeat (2) @(negedge clk_bx);
    check("mid_head0", 64'(bus.out_hit), 64'(exp_q[0]));
    bus.out_ready = 1'b1;
    @(negedge clk_bx);
    check("mid_head1", 64'(bus.out_hit), 64'(exp_q[1]));

    reset        = 1'b1;
    bus.in_data  = '{col: 6'd9, te: 6'd0, le: 6'd0, row: 9'd9};
    bus.in_valid = 1'b1;
    @(negedge clk_bx);
    check("mrst_out_valid", 64'(bus.out_valid), 64'd0);
    check("mrst_out_hit",   64'(bus.out_hit),   64'd0);
    check("mrst_bx_cnt",    64'(bx_cnt),        64'd0);
    check("mrst_ovf_cnt",   64'(ovf_cnt),       64'd0);
    check("mrst_inv_cnt",   64'(inv_cnt),       64'd0);
    reset        = 1'b0;
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk_bx);
    check("post_rst_ignored", 64'(bus.out_valid), 64'd0);
    check("post_rst_bx_cnt",  64'(bx_cnt),        64'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
